// File: rtl/tff_counter_pkg.sv
// Shared types and limits for the T flip-flop counter.
//   cnt_dir_e : count direction encoding (DIR_DOWN = 0, DIR_UP = 1)
//   MAX_WIDTH : largest supported counter width
package tff_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/tff_counter_if.sv
// Control/status bundle for tff_counter.
//   en, up, clr, load, load_val : driven by the controller (master)
//   q, tc, ovf                  : driven by the counter (slave)
interface tff_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val,
    input  q, tc, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output q, tc, ovf
  );
endinterface

// File: rtl/tff_cell.sv
// One bit of the counter: a T flip-flop with async reset, sync clear and load.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, loads rst_val
//   rst_val : reset value of this bit
//   clr     : synchronous clear (beats load and t)
//   load    : synchronous load of d (beats t)
//   d       : load data
//   t       : toggle enable
//   q       : registered bit
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic clr,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else if (clr) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// Up/down counter built from a chain of T flip-flop cells.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (q = RST_VAL, ovf = 0)
//   bus : slave side of tff_counter_if
//         en/up/clr/load/load_val in; q (count), tc (combinational terminal
//         count), ovf (registered one-cycle wrap/blocked-step pulse) out
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  tff_counter_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : gen_width_check
    $error("tff_counter: WIDTH out of range");
  end

  cnt_dir_e         dir;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             tc;
  logic             step_en;
  logic             ovf_d;
  logic             ovf_q;

  assign dir = cnt_dir_e'(bus.up);

  // At a limit the plain toggle rule wraps; in saturate mode we suppress all
  // toggles so the count holds.
  assign tc      = (dir == DIR_UP) ? (&q) : ~(|q);
  assign step_en = bus.en & ~(SATURATE & tc);

  // Bit i toggles when every lower bit is 1 (up) or 0 (down). Each bit uses
  // its own masked reduction so there is no combinational self-reference.
  always_comb begin
    t = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      logic [WIDTH-1:0] mask;
      mask = (WIDTH'(1) << i) - WIDTH'(1);
      if (dir == DIR_UP) begin
        t[i] = step_en & ((q & mask) == mask);
      end else begin
        t[i] = step_en & ((q & mask) == '0);
      end
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_cells
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .clr     (bus.clr),
      .load    (bus.load),
      .d       (bus.load_val[i]),
      .t       (t[i]),
      .q       (q[i])
    );
  end

  // ovf flags a wrap or a blocked step; clr and load take precedence over en.
  assign ovf_d = bus.en & tc & ~bus.clr & ~bus.load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q;
  assign bus.tc  = tc;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_tff_counter.sv
// Self-checking bench for tff_counter: directed scenarios plus a randomized
// scoreboard run against an arithmetic reference model.
module tb_tff_counter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  tff_counter_if #(.WIDTH(4)) b4  ();
  tff_counter_if #(.WIDTH(4)) b4s ();
  tff_counter_if #(.WIDTH(1)) b1  ();
  tff_counter_if #(.WIDTH(8)) b8  ();

  tff_counter #(.WIDTH(4), .RST_VAL(4'd3), .SATURATE(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  tff_counter #(.WIDTH(4), .RST_VAL(4'd0), .SATURATE(1'b1)) u_d4s (
    .clk(clk), .rst(rst), .bus(b4s)
  );
  tff_counter #(.WIDTH(1), .RST_VAL(1'b1), .SATURATE(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  tff_counter #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b1)) u_d8 (
    .clk(clk), .rst(rst), .bus(b8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: next count and ovf from the behavioural rules.
  function automatic void ref_next(input int unsigned w, input bit sat,
                                   input logic [31:0] cur, input bit en, input bit up,
                                   input bit clr, input bit load, input logic [31:0] lv,
                                   output logic [31:0] nxt, output bit novf);
    logic [31:0] maxv;
    maxv = (32'd1 << w) - 32'd1;
    novf = 1'b0;
    nxt  = cur;
    if (clr) begin
      nxt = 0;
    end else if (load) begin
      nxt = lv & maxv;
    end else if (en) begin
      if (up) begin
        if (cur == maxv) begin
          novf = 1'b1;
          nxt  = sat ? cur : 32'd0;
        end else begin
          nxt = cur + 1;
        end
      end else begin
        if (cur == 0) begin
          novf = 1'b1;
          nxt  = sat ? cur : maxv;
        end else begin
          nxt = cur - 1;
        end
      end
    end
  endfunction

  function automatic bit ref_tc(input int unsigned w, input logic [31:0] cur, input bit up);
    logic [31:0] maxv;
    maxv = (32'd1 << w) - 32'd1;
    return up ? (cur == maxv) : (cur == 0);
  endfunction

  task automatic idle_all();
    {b4.en, b4.up, b4.clr, b4.load, b4.load_val}      = '0;
    {b4s.en, b4s.up, b4s.clr, b4s.load, b4s.load_val} = '0;
    {b1.en, b1.up, b1.clr, b1.load, b1.load_val}      = '0;
    {b8.en, b8.up, b8.clr, b8.load, b8.load_val}      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.en = 1'b1;
    b4.up = 1'b1;
    #3;
    n_tests++;
    if (b4.q !== 4'd3) begin
      n_fail++; $display("FAIL reset_q: got %0d expected 3", b4.q);
    end
    n_tests++;
    if (b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b expected 0", b4.ovf);
    end
    n_tests++;
    if (b4.tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc: got %b expected 0", b4.tc);
    end
    #5 rst = 1'b0;
    for (int k = 4; k <= 15; k++) begin
      tick();
      n_tests++;
      if (b4.q !== 4'(k) || b4.ovf !== 1'b0) begin
        n_fail++; $display("FAIL up_count: got q=%0d ovf=%b expected q=%0d ovf=0",
                           b4.q, b4.ovf, k);
      end
    end
    n_tests++;
    if (b4.tc !== 1'b1) begin
      n_fail++; $display("FAIL up_tc_at_15: got %b expected 1", b4.tc);
    end
    tick();
    n_tests++;
    if (b4.q !== 4'd0 || b4.ovf !== 1'b1) begin
      n_fail++; $display("FAIL up_wrap: got q=%0d ovf=%b expected q=0 ovf=1", b4.q, b4.ovf);
    end
    tick();
    n_tests++;
    if (b4.q !== 4'd1 || b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL up_after_wrap: got q=%0d ovf=%b expected q=1 ovf=0",
                         b4.q, b4.ovf);
    end
  endtask

  task automatic test_down_wrap();
    b4.clr = 1'b1;
    tick();
    b4.clr = 1'b0;
    b4.up  = 1'b0;
    b4.en  = 1'b1;
    #1;
    n_tests++;
    if (b4.q !== 4'd0 || b4.tc !== 1'b1) begin
      n_fail++; $display("FAIL down_tc_at_0: got q=%0d tc=%b expected q=0 tc=1", b4.q, b4.tc);
    end
    tick();
    n_tests++;
    if (b4.q !== 4'd15 || b4.ovf !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap: got q=%0d ovf=%b expected q=15 ovf=1", b4.q, b4.ovf);
    end
    tick();
    n_tests++;
    if (b4.q !== 4'd14 || b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL down_after_wrap: got q=%0d ovf=%b expected q=14 ovf=0",
                         b4.q, b4.ovf);
    end
  endtask

  task automatic test_priority();
    b4.clr = 1'b1; b4.load = 1'b1; b4.load_val = 4'd9; b4.en = 1'b1; b4.up = 1'b1;
    tick();
    n_tests++;
    if (b4.q !== 4'd0 || b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL prio_clr: got q=%0d ovf=%b expected q=0 ovf=0", b4.q, b4.ovf);
    end
    b4.clr = 1'b0;
    tick();
    n_tests++;
    if (b4.q !== 4'd9 || b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL prio_load: got q=%0d ovf=%b expected q=9 ovf=0", b4.q, b4.ovf);
    end
    b4.load_val = 4'd15;
    tick();
    n_tests++;
    if (b4.q !== 4'd15 || b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL load_limit: got q=%0d ovf=%b expected q=15 ovf=0", b4.q, b4.ovf);
    end
    b4.load = 1'b0;
    tick();
    n_tests++;
    if (b4.q !== 4'd0 || b4.ovf !== 1'b1) begin
      n_fail++; $display("FAIL wrap_after_load: got q=%0d ovf=%b expected q=0 ovf=1",
                         b4.q, b4.ovf);
    end
  endtask

  task automatic test_async_reset();
    b4.load = 1'b1; b4.load_val = 4'd7; b4.en = 1'b1; b4.up = 1'b1;
    tick();
    b4.load = 1'b0;
    n_tests++;
    if (b4.q !== 4'd7) begin
      n_fail++; $display("FAIL pre_reset_q: got %0d expected 7", b4.q);
    end
    #1 rst = 1'b1;
    #3;
    n_tests++;
    if (b4.q !== 4'd3 || b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got q=%0d ovf=%b expected q=3 ovf=0", b4.q, b4.ovf);
    end
    #3 rst = 1'b0;
    tick();
    n_tests++;
    if (b4.q !== 4'd4 || b4.ovf !== 1'b0) begin
      n_fail++; $display("FAIL resume_after_reset: got q=%0d ovf=%b expected q=4 ovf=0",
                         b4.q, b4.ovf);
    end
    b4.en = 1'b0;
  endtask

  task automatic test_saturate();
    b4s.load = 1'b1; b4s.load_val = 4'd15;
    tick();
    b4s.load = 1'b0; b4s.en = 1'b1; b4s.up = 1'b1;
    #1;
    n_tests++;
    if (b4s.q !== 4'd15 || b4s.tc !== 1'b1) begin
      n_fail++; $display("FAIL sat_load: got q=%0d tc=%b expected q=15 tc=1", b4s.q, b4s.tc);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (b4s.q !== 4'd15 || b4s.ovf !== 1'b1) begin
        n_fail++; $display("FAIL sat_hold: cycle %0d got q=%0d ovf=%b expected q=15 ovf=1",
                           k, b4s.q, b4s.ovf);
      end
    end
    b4s.up = 1'b0;
    tick();
    n_tests++;
    if (b4s.q !== 4'd14 || b4s.ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat_down: got q=%0d ovf=%b expected q=14 ovf=0", b4s.q, b4s.ovf);
    end
    b4s.en = 1'b0;
  endtask

  task automatic test_scoreboard();
    logic [31:0] e1, e4, e8, lv1, lv4, lv8, n1, n4, n8;
    bit          o1, o4, o8;
    bit          en1, up1, cl1, ld1, en4, up4, cl4, ld4, en8, up8, cl8, ld8;
    idle_all();
    rst = 1'b1;
    #2 rst = 1'b0;
    e1 = 32'd1; e4 = 32'd3; e8 = 32'hA5;
    for (int c = 0; c < 1000; c++) begin
      en1 = ($urandom_range(0, 3) != 0); up1 = 1'($urandom_range(0, 1));
      cl1 = ($urandom_range(0, 15) == 0); ld1 = ($urandom_range(0, 7) == 0); lv1 = $urandom;
      en4 = ($urandom_range(0, 3) != 0); up4 = 1'($urandom_range(0, 1));
      cl4 = ($urandom_range(0, 15) == 0); ld4 = ($urandom_range(0, 7) == 0); lv4 = $urandom;
      en8 = ($urandom_range(0, 3) != 0); up8 = ($urandom_range(0, 3) != 0);
      cl8 = ($urandom_range(0, 31) == 0); ld8 = ($urandom_range(0, 15) == 0);
      lv8 = ($urandom_range(0, 1) != 0) ? 32'hFF : $urandom;
      b1.en = en1; b1.up = up1; b1.clr = cl1; b1.load = ld1; b1.load_val = lv1[0:0];
      b4.en = en4; b4.up = up4; b4.clr = cl4; b4.load = ld4; b4.load_val = lv4[3:0];
      b8.en = en8; b8.up = up8; b8.clr = cl8; b8.load = ld8; b8.load_val = lv8[7:0];
      #1;
      n_tests++;
      if (b1.tc !== ref_tc(1, e1, up1) || b4.tc !== ref_tc(4, e4, up4) ||
          b8.tc !== ref_tc(8, e8, up8)) begin
        n_fail++; $display("FAIL sb_tc: cycle %0d got %b%b%b expected %b%b%b", c,
                           b1.tc, b4.tc, b8.tc, ref_tc(1, e1, up1), ref_tc(4, e4, up4),
                           ref_tc(8, e8, up8));
      end
      ref_next(1, 1'b0, e1, en1, up1, cl1, ld1, lv1, n1, o1);
      ref_next(4, 1'b0, e4, en4, up4, cl4, ld4, lv4, n4, o4);
      ref_next(8, 1'b1, e8, en8, up8, cl8, ld8, lv8, n8, o8);
      e1 = n1; e4 = n4; e8 = n8;
      tick();
      n_tests++;
      if (b1.q !== e1[0:0] || b1.ovf !== o1) begin
        n_fail++; $display("FAIL sb_w1: cycle %0d got q=%0d ovf=%b expected q=%0d ovf=%b",
                           c, b1.q, b1.ovf, e1, o1);
      end
      n_tests++;
      if (b4.q !== e4[3:0] || b4.ovf !== o4) begin
        n_fail++; $display("FAIL sb_w4: cycle %0d got q=%0d ovf=%b expected q=%0d ovf=%b",
                           c, b4.q, b4.ovf, e4, o4);
      end
      n_tests++;
      if (b8.q !== e8[7:0] || b8.ovf !== o8) begin
        n_fail++; $display("FAIL sb_w8: cycle %0d got q=%0d ovf=%b expected q=%0d ovf=%b",
                           c, b8.q, b8.ovf, e8, o8);
      end
    end
    idle_all();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle_all();
    test_reset();
    test_down_wrap();
    test_priority();
    test_async_reset();
    test_saturate();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
